// File: rtl/mem_pkg.sv
// Shared memory-access definitions: size encodings, sequencer states
// and load sign/zero extension used by the core and the byte sequencer.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RESP
  } mem_state_e;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    logic [2:0] n;
    unique case (size)
      SZ_BYTE: n = 3'd1;
      SZ_HALF: n = 3'd2;
      SZ_WORD: n = 3'd4;
      default: n = 3'd1;
    endcase
    return n;
  endfunction

  function automatic logic is_err(
    input logic [1:0] size,
    input logic [1:0] addr
  );
    logic e;
    unique case (size)
      SZ_BYTE: e = 1'b0;
      SZ_HALF: e = addr[0];
      SZ_WORD: e = |addr;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] load_extend(
    input logic [31:0] data,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] r;
    unique case (size)
      SZ_BYTE: r = {{24{~uns & data[7]}}, data[7:0]};
      SZ_HALF: r = {{16{~uns & data[15]}}, data[15:0]};
      default: r = data;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_sequencer.sv
// Splits byte/half/word requests into little-endian byte-wide RAM
// accesses, assembles and extends load data, one response per request.
module mem_byte_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic              ram_wren,
  output logic [7:0]        ram_data,
  input  logic [7:0]        ram_q
);

  mem_state_e        r_state;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_n;
  logic [2:0]        r_issue;
  logic [1:0]        r_cap;
  logic [RD_LAT-1:0] r_pipe;
  logic [31:0]       r_asm;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_rden;
  logic              r_ram_wren;
  logic [7:0]        r_ram_data;

  logic              w_err;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_asm;
  logic              w_last_cap;
  logic [RD_LAT:0]   w_pipe_nx;

  assign w_err       = is_err(req_size, req_addr[1:0]);
  assign w_next_addr = r_addr + {{(ADDR_W-3){1'b0}}, r_issue};
  assign w_wbyte     = r_wdata[{r_issue[1:0], 3'b000} +: 8];
  assign w_last_cap  = ({1'b0, r_cap} == (r_n - 3'd1));
  // Delay line of the read strobe marks the cycle each byte arrives
  assign w_pipe_nx   = {r_pipe, r_ram_rden};

  always_comb begin
    w_asm = r_asm;
    w_asm[{r_cap, 3'b000} +: 8] = ram_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_size      <= SZ_BYTE;
      r_uns       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_n         <= '0;
      r_issue     <= '0;
      r_cap       <= '0;
      r_pipe      <= '0;
      r_asm       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_ram_addr  <= '0;
      r_ram_rden  <= 1'b0;
      r_ram_wren  <= 1'b0;
      r_ram_data  <= '0;
    end else begin
      r_pipe     <= w_pipe_nx[RD_LAT-1:0];
      r_ram_rden <= 1'b0;
      r_ram_wren <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_n     <= byte_count(req_size);
            r_issue <= 3'd1;
            r_cap   <= '0;
            r_asm   <= '0;
            if (w_err) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_rdata <= '0;
              r_state     <= ST_RESP;
            end else begin
              r_ram_addr <= req_addr;
              r_ram_rden <= ~req_we;
              r_ram_wren <= req_we;
              if (req_we) r_ram_data <= req_wdata[7:0];
              r_state <= req_we ? ST_WR : ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_issue != r_n) begin
            r_ram_rden <= 1'b1;
            r_ram_addr <= w_next_addr;
            r_issue    <= r_issue + 3'd1;
          end
          if (r_pipe[RD_LAT-1]) begin
            r_asm <= w_asm;
            r_cap <= r_cap + 2'd1;
            if (w_last_cap) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_rsp_rdata <= load_extend(w_asm, r_size, r_uns);
              r_state     <= ST_RESP;
            end
          end
        end
        ST_WR: begin
          if (r_issue != r_n) begin
            r_ram_wren <= 1'b1;
            r_ram_addr <= w_next_addr;
            r_ram_data <= w_wbyte;
            r_issue    <= r_issue + 3'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign ram_addr  = r_ram_addr;
  assign ram_rden  = r_ram_rden;
  assign ram_wren  = r_ram_wren;
  assign ram_data  = r_ram_data;

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Bench for mem_byte_sequencer: byte RAM model with read latency,
// directed scenarios and randomized traffic against a shadow memory.
module tb_mem_byte_sequencer;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] ram_addr;
  logic        ram_rden;
  logic        ram_wren;
  logic [7:0]  ram_data;
  logic [7:0]  ram_q;

  mem_byte_sequencer #(.ADDR_W(16), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_data(ram_data),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];
  logic [7:0] qp [0:RD_LAT-1];

  always @(posedge clk) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    qp[0] <= ram_rden ? mem[ram_addr] : 8'h5A;
    for (int i = 1; i < RD_LAT; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RD_LAT-1];

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  int t_acc = 0;
  int rsp_cyc = 0;
  int rsp_cnt = 0;
  bit rsp_seen = 0;
  int both_cnt = 0;
  logic [15:0] wa_q[$];
  logic [7:0]  wd_q[$];
  int          wc_q[$];
  logic [15:0] ra_q[$];
  int          rc_q[$];

  always @(posedge clk) begin
    cyc++;
    if (ram_wren) begin
      wa_q.push_back(ram_addr);
      wd_q.push_back(ram_data);
      wc_q.push_back(cyc);
    end
    if (ram_rden) begin
      ra_q.push_back(ram_addr);
      rc_q.push_back(cyc);
    end
    if (ram_rden && ram_wren) both_cnt++;
    if (rsp_valid) begin
      if (!rsp_seen) begin
        rsp_seen = 1;
        rsp_cyc = cyc;
      end
      rsp_cnt++;
    end
  end

  function automatic logic [31:0] model_load(
    input logic [15:0] a, input logic [1:0] sz, input logic uns
  );
    int nb;
    longint v;
    nb = 1 << sz;
    v = 0;
    for (int k = 0; k < nb; k++)
      v += longint'(ref_mem[16'(a + k)]) << (8 * k);
    if ((!uns || sz == 2'b10) && v >= (longint'(1) << (8 * nb - 1)))
      v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  function automatic bit model_err(input logic [15:0] a, input logic [1:0] sz);
    if (sz == 2'b11) return 1;
    return (int'(a) % (1 << sz)) != 0;
  endfunction

  task automatic start_req(
    input logic we, input logic [1:0] sz, input logic uns,
    input logic [15:0] a, input logic [31:0] wd, output bit ok
  );
    int g;
    g = 0;
    req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; req_valid = 1'b1;
    while (!req_ready && g < 20) begin
      @(posedge clk); #1; g++;
    end
    ok = req_ready;
    wa_q.delete(); wd_q.delete(); wc_q.delete();
    ra_q.delete(); rc_q.delete();
    rsp_seen = 0; rsp_cnt = 0;
    @(posedge clk); #1;
    t_acc = cyc;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 16'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_rsp(output bit ok, output logic [31:0] d, output logic e);
    int g;
    g = 0;
    while (!rsp_valid && g < 40) begin
      @(posedge clk); #1; g++;
    end
    ok = rsp_valid; d = rsp_rdata; e = rsp_err;
  endtask

  task automatic xact(
    input logic we, input logic [1:0] sz, input logic uns,
    input logic [15:0] a, input logic [31:0] wd,
    output bit ok, output logic [31:0] d, output logic e, output int lat
  );
    bit ok1, ok2;
    start_req(we, sz, uns, a, wd, ok1);
    wait_rsp(ok2, d, e);
    @(posedge clk); #1;
    ok = ok1 && ok2;
    lat = rsp_cyc - t_acc;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vecs++;
    if (req_ready !== 1'b0) begin
      errs++; $display("FAIL reset_ready got %b want 0", req_ready);
    end
    vecs++;
    if ({rsp_valid, rsp_err, ram_rden, ram_wren} !== 4'b0) begin
      errs++;
      $display("FAIL reset_flags got %b want 0000",
               {rsp_valid, rsp_err, ram_rden, ram_wren});
    end
    vecs++;
    if ({rsp_rdata, ram_addr, ram_data} !== 56'h0) begin
      errs++;
      $display("FAIL reset_data got %h want 0", {rsp_rdata, ram_addr, ram_data});
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++; $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_word_load;
    bit ok; logic [31:0] d; logic e; int lat;
    logic [7:0] b [4];
    b = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int k = 0; k < 4; k++) begin
      mem[16'h10 + k] = b[k]; ref_mem[16'h10 + k] = b[k];
    end
    xact(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || d !== 32'h12345678 || e !== 1'b0) begin
      errs++;
      $display("FAIL word_load got ok=%0d %h err=%b want 12345678 err=0", ok, d, e);
    end
    vecs++;
    if (lat != 4 + RD_LAT + 1) begin
      errs++; $display("FAIL word_load_lat got %0d want %0d", lat, 4 + RD_LAT + 1);
    end
    vecs++;
    if (ra_q.size() != 4 || ra_q[0] !== 16'h10 || ra_q[3] !== 16'h13 ||
        rc_q[0] - t_acc != 1 || rc_q[3] - t_acc != 4) begin
      errs++;
      $display("FAIL word_load_strobes got n=%0d want 4 at 0x10..0x13 cycles 1..4",
               ra_q.size());
    end
  endtask

  task automatic test_byte_sign;
    bit ok; logic [31:0] d; logic e; int lat;
    mem[16'h3] = 8'h80; ref_mem[16'h3] = 8'h80;
    xact(1'b0, 2'b00, 1'b0, 16'h0003, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || d !== 32'hFFFFFF80 || lat != 1 + RD_LAT + 1) begin
      errs++;
      $display("FAIL byte_signed got %h lat=%0d want ffffff80 lat=%0d", d, lat, RD_LAT + 2);
    end
    xact(1'b0, 2'b00, 1'b1, 16'h0003, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || d !== 32'h00000080) begin
      errs++; $display("FAIL byte_unsigned got %h want 00000080", d);
    end
  endtask

  task automatic test_half_store;
    bit ok; logic [31:0] d; logic e; int lat;
    xact(1'b1, 2'b01, 1'b0, 16'h0020, 32'hDEADBEEF, ok, d, e, lat);
    ref_mem[16'h20] = 8'hEF; ref_mem[16'h21] = 8'hBE;
    vecs++;
    if (!ok || lat != 3 || e !== 1'b0 || d !== 32'h0) begin
      errs++;
      $display("FAIL half_store_rsp got lat=%0d err=%b d=%h want 3 0 0", lat, e, d);
    end
    vecs++;
    if (wa_q.size() != 2 || ra_q.size() != 0 ||
        wa_q[0] !== 16'h20 || wd_q[0] !== 8'hEF || wc_q[0] - t_acc != 1 ||
        wa_q[1] !== 16'h21 || wd_q[1] !== 8'hBE || wc_q[1] - t_acc != 2) begin
      errs++;
      $display("FAIL half_store_strobes got nw=%0d nr=%0d want 2 writes EF@20 BE@21",
               wa_q.size(), ra_q.size());
    end
    vecs++;
    if (ram_addr !== 16'h21 || ram_data !== 8'hBE) begin
      errs++;
      $display("FAIL half_store_hold got %h/%h want 0021/be", ram_addr, ram_data);
    end
    xact(1'b0, 2'b01, 1'b0, 16'h0020, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || d !== 32'hFFFFBEEF) begin
      errs++; $display("FAIL half_readback got %h want ffffbeef", d);
    end
  endtask

  task automatic test_errors;
    bit ok; logic [31:0] d; logic e; int lat;
    xact(1'b0, 2'b10, 1'b0, 16'h0002, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || lat != 1 || ra_q.size() + wa_q.size() != 0) begin
      errs++;
      $display("FAIL err_misaligned got err=%b d=%h lat=%0d strobes=%0d want 1 0 1 0",
               e, d, lat, ra_q.size() + wa_q.size());
    end
    xact(1'b1, 2'b11, 1'b0, 16'h0000, 32'h12345678, ok, d, e, lat);
    vecs++;
    if (!ok || e !== 1'b1 || d !== 32'h0 || lat != 1 || ra_q.size() + wa_q.size() != 0) begin
      errs++;
      $display("FAIL err_size11 got err=%b d=%h lat=%0d strobes=%0d want 1 0 1 0",
               e, d, lat, ra_q.size() + wa_q.size());
    end
    vecs++;
    if (rsp_cnt != 1) begin
      errs++; $display("FAIL err_one_cycle got %0d cycles want 1", rsp_cnt);
    end
  endtask

  task automatic test_backpressure;
    bit ok1, ok2; logic [31:0] d; logic e;
    int bad;
    bad = 0;
    mem[16'h30] = 8'hC3; ref_mem[16'h30] = 8'hC3;
    rsp_ready = 1'b0;
    start_req(1'b0, 2'b00, 1'b1, 16'h0030, 32'h0, ok1);
    wait_rsp(ok2, d, e);
    vecs++;
    if (!ok1 || !ok2 || d !== 32'h000000C3) begin
      errs++; $display("FAIL bp_data got %h want 000000c3", d);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== d || req_ready !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    vecs++;
    if (req_ready !== 1'b0) begin
      errs++; $display("FAIL bp_ready_in_handshake got %b want 0", req_ready);
    end
    @(posedge clk); #1;
    vecs++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errs++;
      $display("FAIL bp_after_handshake got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid;
    bit ok; logic [31:0] d; logic e; int lat;
    logic [7:0] old42;
    old42 = ref_mem[16'h42];
    start_req(1'b1, 2'b10, 1'b0, 16'h0040, 32'hA1B2C3D4, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (!ok || ram_wren !== 1'b0 || ram_rden !== 1'b0 || rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_mid_strobes got wren=%b rden=%b valid=%b want 0 0 0",
               ram_wren, ram_rden, rsp_valid);
    end
    rst = 1'b0;
    #1;
    vecs++;
    if (req_ready !== 1'b1) begin
      errs++; $display("FAIL rst_mid_ready got %b want 1", req_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    ref_mem[16'h40] = 8'hD4; ref_mem[16'h41] = 8'hC3;
    vecs++;
    if (rsp_cnt != 0 || wa_q.size() != 2 || mem[16'h42] !== old42 || mem[16'h41] !== 8'hC3) begin
      errs++;
      $display("FAIL rst_mid_abort got rsp=%0d writes=%0d want 0 2", rsp_cnt, wa_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      mem[16'hFFFC + k] = 8'(8'h11 * (k + 1));
      ref_mem[16'hFFFC + k] = 8'(8'h11 * (k + 1));
    end
    xact(1'b0, 2'b10, 1'b0, 16'hFFFC, 32'h0, ok, d, e, lat);
    vecs++;
    if (!ok || d !== 32'h44332211 || e !== 1'b0 || lat != 4 + RD_LAT + 1) begin
      errs++;
      $display("FAIL top_word_load got %h err=%b lat=%0d want 44332211 0 %0d",
               d, e, lat, 4 + RD_LAT + 1);
    end
  endtask

  task automatic test_random;
    bit ok; logic [31:0] d, exp_d; logic e; int lat, exp_lat, nb, r;
    logic [1:0] sz; logic [15:0] a; logic we, uns; logic [31:0] wd;
    bit exp_e;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      nb = (sz == 2'b11) ? 1 : (1 << sz);
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) a = 16'((int'(a) / nb) * nb);
      we = 1'($urandom); uns = 1'($urandom); wd = $urandom;
      exp_e = model_err(a, sz);
      exp_d = (exp_e || we) ? 32'h0 : model_load(a, sz, uns);
      exp_lat = exp_e ? 1 : we ? nb + 1 : nb + RD_LAT + 1;
      xact(we, sz, uns, a, wd, ok, d, e, lat);
      vecs++;
      if (!ok || d !== exp_d || e !== exp_e || lat != exp_lat) begin
        errs++;
        $display("FAIL rnd%0d we=%b sz=%0d a=%h got %h err=%b lat=%0d want %h %b %0d",
                 t, we, sz, a, d, e, lat, exp_d, exp_e, exp_lat);
      end
      vecs++;
      if (wa_q.size() != ((!exp_e && we) ? nb : 0) ||
          ra_q.size() != ((!exp_e && !we) ? nb : 0) || rsp_cnt != 1) begin
        errs++;
        $display("FAIL rnd%0d_strobes got w=%0d r=%0d rsp=%0d", t,
                 wa_q.size(), ra_q.size(), rsp_cnt);
      end
      if (!exp_e && we) begin
        for (int k = 0; k < nb; k++) begin
          vecs++;
          if (k >= wa_q.size() || wa_q[k] !== 16'(a + k) ||
              wd_q[k] !== wd[8*k +: 8]) begin
            errs++;
            $display("FAIL rnd%0d_wbyte%0d want %h@%h", t, k, wd[8*k +: 8], 16'(a + k));
          end
          ref_mem[16'(a + k)] = wd[8*k +: 8];
        end
      end
    end
    vecs++;
    if (both_cnt != 0) begin
      errs++; $display("FAIL both_strobes got %0d want 0", both_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    for (int i = 0; i < RD_LAT; i++) qp[i] = 8'h00;
    test_reset();
    test_word_load();
    test_byte_sign();
    test_half_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Memory responder that sits between the processor's fetch/load/store path and the byte-wide `system_ram`. It accepts one byte, halfword or word request at a time and issues the 1, 2 or 4 byte-wide RAM accesses that request needs, in little-endian order. For reads it assembles the bytes and sign- or zero-extends the result. It returns a single response per request and flags illegal or misaligned accesses without touching RAM.

## Interface
Parameters:
- `ADDR_W`, 16: byte address width; matches `system_ram` depth.
- `RD_LAT`, 2: cycles from `ram_rden` sampled high to valid `ram_q`; legal range 1..3.

Ports:
- `clk`  in  1  system clock (CLOCK_50 domain).
- `rst`  in  1  reset; one clock, reset is synchronous and active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle and able to accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  access size: 00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; only the low 1, 2 or 4 bytes are used.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  illegal size or misaligned address.
- `ram_addr`  out  ADDR_W  RAM byte address.
- `ram_rden`  out  1  RAM read strobe.
- `ram_wren`  out  1  RAM write strobe.
- `ram_data`  out  8  RAM write byte.
- `ram_q`  in  8  RAM read byte.

## Operation
- Byte count n: 1 for size 00, 2 for size 01, 4 for size 10.
- Error conditions:
  - size 11;
  - size 01 with `addr[0]` = 1;
  - size 10 with `addr[1:0]` ≠ 0.
  - On error there are no RAM strobes. The block goes straight to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- Byte k (k = 0..n-1) uses address `req_addr`+k. No carry out is possible, because aligned accesses never cross the top of memory; a word at 0xFFFC uses 0xFFFC..0xFFFF.
- Loads:
  - byte k from `ram_q` lands in `rdata[8k+7:8k]`;
  - upper bits are filled with the top bit of byte n-1 (signed) or with 0 (unsigned);
  - for words, `req_unsigned` is ignored.
- Stores: byte k = `req_wdata[8k+7:8k]`.
- Request fields are registered on acceptance. Later changes to the inputs have no effect on the request in progress.
- States:
  - IDLE: `req_ready`=1; `req_valid` → ERRCHK result selects RD, WR or RESP(err).
  - RD: one `ram_rden` pulse per cycle for n cycles on consecutive addresses. A capture counter samples `ram_q` `RD_LAT` cycles after each strobe. Go to RESP after the last capture.
  - WR: one `ram_wren` pulse per cycle for n cycles. Go to RESP after the last pulse.
  - RESP: `rsp_valid`=1, data held stable. When `rsp_valid` and `rsp_ready` are both high → IDLE.
- `ram_rden` and `ram_wren` are never high in the same cycle.
- `ram_addr` and `ram_data` are held at their last value when no strobe is high.

## Timing
- Reset values: `req_ready`=0 while `rst` is high and 1 in the first cycle after release; `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `ram_rden`=0, `ram_wren`=0, `ram_addr`=0, `ram_data`=0; state = IDLE.
- Latency is counted from accept edge T (`req_valid` and `req_ready` both high):
  - first strobe is in cycle T+1;
  - last strobe is in cycle T+n;
  - load: `rsp_valid` rises at T+n+`RD_LAT`+1;
  - store: `rsp_valid` rises at T+n+1;
  - error: `rsp_valid` rises at T+1.
- `req_ready` is low from T+1 until the cycle after the response handshake. No back-to-back acceptance is allowed in the handshake cycle itself.
- If `rsp_ready` is already high when `rsp_valid` rises, the response lasts exactly 1 cycle.
- Reset mid-operation: strobes drop at the next edge and the block returns to IDLE. A partially written word may remain in RAM; this is accepted behaviour. No response is issued for the aborted request.

## Structure
- Shared package `mem_pkg`:
  - size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - FSM state enum (IDLE, RD, WR, RESP);
  - function `load_extend(data, size, unsigned)`.
- The processor's decode/execute stages import the same size constants.
- No sub-module. FSM, issue counter, capture counter (`RD_LAT`-deep delay of the rden strobe) and assembly register live in one module.

## Test plan
- Word load at 0x0010, RAM bytes 0x78, 0x56, 0x34, 0x12, `RD_LAT`=2 → rdata 0x12345678, err=0, `rsp_valid` at T+7.
- Signed byte load at 0x0003 with RAM 0x80 → rdata 0xFFFFFF80; the same access with unsigned → 0x00000080.
- Halfword store 0xDEADBEEF at 0x0020 → `ram_wren` at T+1 (addr 0x20, data 0xEF) and T+2 (addr 0x21, data 0xBE); `rsp_valid` at T+3.
- Word load at 0x0002 and size 11 at 0x0000 → `rsp_valid` at T+1 with err=1, rdata 0, no RAM strobes.
- `rsp_ready` held low for 5 cycles → `rsp_valid` and data stable throughout; `req_ready` low until the cycle after the handshake.
- `rst` asserted between the 2nd and 3rd byte of a word store → strobes low at the next edge, no response, `req_ready`=1 in the cycle after `rst` falls; a following word load at 0xFFFC returns the correct bytes.
